// File: rtl/multi_edge_load.sv
// multi_edge_load: per-channel frame-sync conditioner for the SDRAM controller
// clock domain. Each channel synchronises an asynchronous sync input, rejects
// short glitches, detects a runtime-selected edge and turns an accepted edge
// into a LOAD pulse of fixed width. Each channel also keeps a wrapping event
// counter and a sticky flag for edges dropped while a pulse was in progress.
//
// Handshake note: there is no valid/ready pairing here. o_load is a pure
// strobe (PULSE_W cycles high per accepted edge); o_level, o_cnt and o_miss
// are level outputs that are valid on every cycle outside reset.
module multi_edge_load #(
  parameter int CH          = 3,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4,
  parameter int PULSE_W     = 1,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       i_sig,
  input  logic [2*CH-1:0]     i_mode,
  input  logic                i_clr,
  output logic [CH-1:0]       o_load,
  output logic [CH-1:0]       o_level,
  output logic [CH*CNT_W-1:0] o_cnt,
  output logic [CH-1:0]       o_miss
);

  localparam int FC_W = $clog2(FILT_CYC) + 1;
  localparam int PC_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYC - 1);
  localparam logic [PC_W-1:0] PC_INIT = PC_W'(PULSE_W - 1);

  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  for (genvar n = 0; n < CH; n++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [FC_W-1:0]        fc;
    logic                   lvl;
    logic                   lvl_d;
    logic [1:0]             mode;
    logic                   rise;
    logic                   fall;
    logic                   qualify;
    logic [PC_W-1:0]        pc;
    logic                   load;
    logic [CNT_W-1:0]       cnt;
    logic                   miss;

    assign s    = sync[SYNC_STAGES-1];
    assign mode = i_mode[2*n +: 2];

    // Shift the raw input through the synchroniser chain; the last stage is s.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], i_sig[n]};
      end
    end

    // Accept a new level only after it has differed from lvl for FILT_CYC
    // consecutive cycles; any return to lvl restarts the run.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        fc  <= '0;
        lvl <= 1'b0;
      end else if (s == lvl) begin
        fc <= '0;
      end else if (fc == FC_LAST) begin
        lvl <= s;
        fc  <= '0;
      end else begin
        fc <= fc + 1'b1;
      end
    end

    // Delay the filtered level by one cycle for edge detection.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lvl_d <= 1'b0;
      end else begin
        lvl_d <= lvl;
      end
    end

    // Edge classification against the mode currently presented on i_mode.
    always_comb begin
      rise    = lvl & ~lvl_d;
      fall    = ~lvl & lvl_d;
      qualify = 1'b0;
      case (mode)
        MODE_RISE: qualify = rise;
        MODE_FALL: qualify = fall;
        MODE_BOTH: qualify = rise | fall;
        default:   qualify = 1'b0;
      endcase
    end

    // Pulse generator: a qualifying edge while idle starts a PULSE_W-cycle
    // pulse; a running pulse always completes and is never retriggered.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        load <= 1'b0;
        pc   <= '0;
      end else if (load) begin
        if (pc == '0) begin
          load <= 1'b0;
        end else begin
          pc <= pc - 1'b1;
        end
      end else if (qualify) begin
        load <= 1'b1;
        pc   <= PC_INIT;
      end
    end

    // Event counter and sticky miss flag; a clear overrides both updates.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt  <= '0;
        miss <= 1'b0;
      end else if (i_clr) begin
        cnt  <= '0;
        miss <= 1'b0;
      end else if (qualify) begin
        if (load) begin
          miss <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign o_load[n]                = load;
    assign o_level[n]               = lvl;
    assign o_cnt[n*CNT_W +: CNT_W]  = cnt;
    assign o_miss[n]                = miss;
  end

endmodule
